// File: rtl/cu_pkg.sv
// Shared definitions for the ID-stage main control decoder: opcodes, ALU-op
// encodings, the decoded control-line record and ID/EX bundle bit positions.
package cu_pkg;

    localparam int OPW = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'h00;
    localparam logic [OPW-1:0] OP_FP    = 6'h11;
    localparam logic [OPW-1:0] OP_ADDI  = 6'h08;
    localparam logic [OPW-1:0] OP_ANDI  = 6'h0C;
    localparam logic [OPW-1:0] OP_ORI   = 6'h0D;
    localparam logic [OPW-1:0] OP_SLTI  = 6'h0A;
    localparam logic [OPW-1:0] OP_LW    = 6'h23;
    localparam logic [OPW-1:0] OP_SW    = 6'h2B;
    localparam logic [OPW-1:0] OP_BEQ   = 6'h04;
    localparam logic [OPW-1:0] OP_J     = 6'h02;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IMM   = 2'b11;

    // Bundle vectors are ascending [0:N]; index 0 is the first-listed signal.
    localparam int WB_REG_WRITE  = 0;
    localparam int WB_MEM_TO_REG = 1;
    localparam int M_BRANCH      = 0;
    localparam int M_MEM_READ    = 1;
    localparam int M_MEM_WRITE   = 2;
    localparam int EX_REG_DST    = 0;
    localparam int EX_ALU_SRC    = 1;

    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
        logic       branch;
        logic       jump;
        logic [1:0] alu_op;
    } ctrl_t;

endpackage

// File: rtl/cu_main_decoder.sv
// Purely combinational opcode -> control-line table. Unlisted opcodes decode
// to an all-zero NOP so they cause no architectural side effect.
module cu_main_decoder
    import cu_pkg::*;
(
    input  logic [OPW-1:0] i_opcode,
    output ctrl_t          o_ctrl
);

    always_comb begin
        // NOTE: assign every output a default before the case so no path leaves it unassigned (avoids inferred latches).
        o_ctrl = '0;
        case (i_opcode)
            OP_RTYPE, OP_FP: begin
                o_ctrl.reg_dst   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_FUNCT;
            end
            OP_ADDI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_ANDI, OP_ORI, OP_SLTI: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.reg_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_IMM;
            end
            OP_LW: begin
                o_ctrl.alu_src    = 1'b1;
                o_ctrl.mem_read   = 1'b1;
                o_ctrl.mem_to_reg = 1'b1;
                o_ctrl.reg_write  = 1'b1;
                o_ctrl.alu_op     = ALUOP_ADD;
            end
            OP_SW: begin
                o_ctrl.alu_src   = 1'b1;
                o_ctrl.mem_write = 1'b1;
                o_ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BEQ: begin
                o_ctrl.branch = 1'b1;
                o_ctrl.alu_op = ALUOP_SUB;
            end
            OP_J: begin
                o_ctrl.jump   = 1'b1;
                o_ctrl.alu_op = ALUOP_ADD;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// ID-stage main control: drives decoded control lines combinationally (held at
// zero during reset) and registers the WB/M/EX bundles into the ID/EX latch.
module control_unit #(
    parameter int OPW = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] instruction_nibble,
    output logic           reg_dst,
    output logic           branch,
    output logic           mem_read,
    output logic           mem_to_reg,
    output logic           alu_src,
    output logic           reg_write,
    output logic           mem_write,
    output logic [1:0]     alu_op,
    output logic           jump,
    output logic           pc_src,
    output logic [0:1]     WB,
    output logic [0:2]     M,
    output logic [0:1]     EX,
    output logic [1:0]     EX_alu_op
);

    import cu_pkg::*;

    ctrl_t      w_dec;
    ctrl_t      w_ctrl;
    logic [0:1] r_wb;
    logic [0:2] r_m;
    logic [0:1] r_ex;
    logic [1:0] r_ex_alu_op;

    cu_main_decoder u_main_decoder (
        .i_opcode (instruction_nibble),
        .o_ctrl   (w_dec)
    );

    assign w_ctrl = rst_n ? w_dec : '0;

    assign reg_dst    = w_ctrl.reg_dst;
    assign branch     = w_ctrl.branch;
    assign mem_read   = w_ctrl.mem_read;
    assign mem_to_reg = w_ctrl.mem_to_reg;
    assign alu_src    = w_ctrl.alu_src;
    assign reg_write  = w_ctrl.reg_write;
    assign mem_write  = w_ctrl.mem_write;
    assign alu_op     = w_ctrl.alu_op;
    assign jump       = w_ctrl.jump;
    assign pc_src     = w_ctrl.branch | w_ctrl.jump;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb        <= '0;
            r_m         <= '0;
            r_ex        <= '0;
            r_ex_alu_op <= '0;
        end else begin
            // NOTE: non-blocking assignments so every bundle bit samples the pre-edge decode together.
            r_wb[WB_REG_WRITE]  <= w_dec.reg_write;
            r_wb[WB_MEM_TO_REG] <= w_dec.mem_to_reg;
            r_m[M_BRANCH]       <= w_dec.branch;
            r_m[M_MEM_READ]     <= w_dec.mem_read;
            r_m[M_MEM_WRITE]    <= w_dec.mem_write;
            r_ex[EX_REG_DST]    <= w_dec.reg_dst;
            r_ex[EX_ALU_SRC]    <= w_dec.alu_src;
            r_ex_alu_op         <= w_dec.alu_op;
        end
    end

    assign WB        = r_wb;
    assign M         = r_m;
    assign EX        = r_ex;
    assign EX_alu_op = r_ex_alu_op;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: the driver pushes the expected ID/EX bundle
// for every opcode it issues; an independent monitor pops and compares after each edge.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [5:0] instruction_nibble;
    logic       reg_dst, branch, mem_read, mem_to_reg, alu_src;
    logic       reg_write, mem_write, jump, pc_src;
    logic [1:0] alu_op;
    logic [0:1] WB;
    logic [0:2] M;
    logic [0:1] EX;
    logic [1:0] EX_alu_op;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] last_exp;

    control_unit #(.OPW(6)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .instruction_nibble (instruction_nibble),
        .reg_dst            (reg_dst),
        .branch             (branch),
        .mem_read           (mem_read),
        .mem_to_reg         (mem_to_reg),
        .alu_src            (alu_src),
        .reg_write          (reg_write),
        .mem_write          (mem_write),
        .alu_op             (alu_op),
        .jump               (jump),
        .pc_src             (pc_src),
        .WB                 (WB),
        .M                  (M),
        .EX                 (EX),
        .EX_alu_op          (EX_alu_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode written straight from the opcode table:
    // {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, alu_op}
    function automatic logic [9:0] model(input logic [5:0] op);
        case (op)
            6'h00, 6'h11:        return 10'b1_0_0_0_0_1_0_0_10;
            6'h08:               return 10'b0_1_0_0_0_1_0_0_00;
            6'h0C, 6'h0D, 6'h0A: return 10'b0_1_0_0_0_1_0_0_11;
            6'h23:               return 10'b0_1_1_0_1_1_0_0_00;
            6'h2B:               return 10'b0_1_0_1_0_0_0_0_00;
            6'h04:               return 10'b0_0_0_0_0_0_1_0_01;
            6'h02:               return 10'b0_0_0_0_0_0_0_1_00;
            default:             return 10'b0;
        endcase
    endfunction

    // Expected {WB, M, EX, EX_alu_op} rebuilt from the named fields of the decode.
    function automatic logic [8:0] bundles(input logic [9:0] m);
        logic rd, as_, mr, mw, m2r, rw, br, j;
        logic [1:0] op;
        {rd, as_, mr, mw, m2r, rw, br, j, op} = m;
        return {rw, m2r, br, mr, mw, rd, as_, op};
    endfunction

    function automatic logic [9:0] comb_act();
        return {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump, alu_op};
    endfunction

    task automatic check_comb(input string tag, input logic [5:0] op, input logic [9:0] m);
        check($sformatf("%s_comb_op%02h", tag, op), {22'd0, comb_act()}, {22'd0, m});
        check($sformatf("%s_pcsrc_op%02h", tag, op), {31'd0, pc_src}, {31'd0, m[3] | m[2]});
    endtask

    task automatic issue(input logic [5:0] op);
        @(negedge clk);
        instruction_nibble = op;
        last_exp = bundles(model(op));
        exp_q.push_back(last_exp);
        #1;
        check_comb("issue", op, model(op));
    endtask

    // Monitor: after every edge, any pending expectation belongs to that edge.
    initial begin
        logic [8:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("bundles", {23'd0, WB, M, EX, EX_alu_op}, {23'd0, e});
            end
        end
    end

    localparam logic [5:0] VALID_OPS [10] = '{6'h00, 6'h11, 6'h08, 6'h0C, 6'h0D,
                                              6'h0A, 6'h23, 6'h2B, 6'h04, 6'h02};

    initial begin
        logic [5:0] op;
        rst_n = 1'b0;
        instruction_nibble = 6'h23;
        #2;
        check("rst_comb", {22'd0, comb_act()}, 32'd0);
        check("rst_pcsrc", {31'd0, pc_src}, 32'd0);
        check("rst_bundles", {23'd0, WB, M, EX, EX_alu_op}, 32'd0);
        @(posedge clk);
        #1;
        check("rst_hold_bundles", {23'd0, WB, M, EX, EX_alu_op}, 32'd0);

        // Release with lw still on the bus: the first edge captures it.
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = bundles(model(6'h23));
        exp_q.push_back(last_exp);
        #1;
        check_comb("release", 6'h23, model(6'h23));

        issue(6'h08);
        issue(6'h00);
        issue(6'h2B);
        issue(6'h04);
        issue(6'h02);
        issue(6'h11);
        issue(6'h3F);

        // Opcode changes mid-cycle: combinational follows, registers hold.
        issue(6'h23);
        @(posedge clk);
        #3;
        instruction_nibble = 6'h3F;
        #1;
        check_comb("midcycle", 6'h3F, model(6'h3F));
        check("midcycle_hold", {23'd0, WB, M, EX, EX_alu_op}, {23'd0, last_exp});

        // Async reset between edges clears bundles without a clock.
        issue(6'h23);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_bundles", {23'd0, WB, M, EX, EX_alu_op}, 32'd0);
        check("async_rst_comb", {22'd0, comb_act()}, 32'd0);
        @(posedge clk);
        #1;
        check("async_rst_hold", {23'd0, WB, M, EX, EX_alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom_range(0, 63));
            else op = VALID_OPS[$urandom_range(0, 9)];
            issue(op);
        end

        @(posedge clk);
        #3;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
